load_store_unit: RTL and testbench

Sequencer between the core's memory stage and the word-only data memory. It accepts one load or store request at a time and checks its alignment and address range. Sub-word stores become a read-modify-write, because the memory has no byte enables. Loaded bytes and halfwords are extracted and sign- or zero-extended, with a registered one-cycle response pulse back to the core.

---
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer between the core memory stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extracted and extended.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t      state, state_nxt;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr, lat_wdata, merge_buf;
  logic        accept, bad_funct3, misaligned, out_of_range;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data, merge_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Classification works on the live request so the response can be registered on the accept edge.
  always_comb begin
    bad_funct3   = req_store ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                             : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
    misaligned   = !bad_funct3 &&
                   (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    out_of_range = (req_addr >= 32'(MEM_BYTES));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: if (accept && !bad_funct3 && !misaligned && !out_of_range)
              state_nxt = (req_store && (req_funct3 == 3'b010)) ? WR : RD;
      RD: begin
        mem_read  = 1'b1;
        state_nxt = CAP;
      end
      CAP: state_nxt = lat_store ? WR : IDLE;
      WR: begin
        mem_write = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = (mem_read | mem_write) ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_write ? ((lat_funct3 == 3'b010) ? lat_wdata : merge_buf) : 32'h0;

  always_comb begin
    ld_byte = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
    ld_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mem_rdata;
    endcase
    merge_data = mem_rdata;
    if (lat_funct3[1:0] == 2'b00) merge_data[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    else                          merge_data[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
  end

  // Response fields default to 0 every cycle so they only carry data during the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_store       <= 1'b0;
      lat_funct3      <= 3'b000;
      lat_addr        <= 32'h0;
      lat_wdata       <= 32'h0;
      merge_buf       <= 32'h0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else begin
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
      if (accept) begin
        lat_store       <= req_store;
        lat_funct3      <= req_funct3;
        lat_addr        <= req_addr;
        lat_wdata       <= req_wdata;
        resp_valid      <= bad_funct3 | misaligned | out_of_range;
        resp_misaligned <= misaligned;
        resp_fault      <= bad_funct3 | (!misaligned & out_of_range);
      end
      if (state == CAP) begin
        if (lat_store) merge_buf <= merge_data;
        else begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
      end
      if (state == WR) resp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory attached to the memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:31];
  int          total = 0;
  int          bad = 0;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read memory, cleared by the same reset as the unit.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[6:2]];
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(logic st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    @(negedge clk);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    chk("ready_idle", req_ready, 1);
  endtask

  // kind: 0 fault/misaligned, 1 SW, 2 load, 3 read-modify-write store
  task automatic run(string tag, int kind, logic [31:0] ea, logic [31:0] ewd,
                     logic [31:0] erd, logic emis, logic eflt);
    int  lat;
    logic exp_rd, exp_wr;
    lat = (kind == 0) ? 1 : (kind == 1) ? 2 : (kind == 2) ? 3 : 4;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      exp_rd = (kind >= 2) && (c == 1);
      exp_wr = ((kind == 1) && (c == 1)) || ((kind == 3) && (c == 3));
      chk({tag, "_mem_read"}, mem_read, exp_rd);
      chk({tag, "_mem_write"}, mem_write, exp_wr);
      chk({tag, "_resp_valid"}, resp_valid, (c == lat));
      chk({tag, "_req_ready"}, req_ready, (c == lat));
      if (exp_rd || exp_wr) chk({tag, "_mem_addr"}, mem_addr, ea);
      else                  chk({tag, "_mem_addr_idle"}, mem_addr, 0);
      if (exp_wr) chk({tag, "_mem_wdata"}, mem_wdata, ewd);
      if (c == lat) begin
        chk({tag, "_rdata"}, resp_rdata, erd);
        chk({tag, "_misaligned"}, resp_misaligned, emis);
        chk({tag, "_fault"}, resp_fault, eflt);
      end
      if (c == 1) req_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_resp_clear"}, {resp_valid, resp_misaligned, resp_fault}, 0);
    chk({tag, "_rdata_clear"}, resp_rdata, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_misaligned, resp_fault, mem_read, mem_write}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;

    issue(1, 3'b010, 32'h10, 32'hDEADBEEF);
    run("sw10", 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    issue(0, 3'b010, 32'h10, 32'h0);
    run("lw10", 2, 32'h10, 0, 32'hDEADBEEF, 0, 0);

    issue(1, 3'b010, 32'h10, 32'h11223344);
    run("sw_base", 1, 32'h10, 32'h11223344, 0, 0, 0);
    issue(1, 3'b000, 32'h13, 32'h123456A5);
    run("sb13", 3, 32'h10, 32'hA5223344, 0, 0, 0);
    issue(0, 3'b000, 32'h13, 32'h0);
    run("lb13", 2, 32'h10, 0, 32'hFFFFFFA5, 0, 0);
    issue(0, 3'b100, 32'h13, 32'h0);
    run("lbu13", 2, 32'h10, 0, 32'h000000A5, 0, 0);

    issue(1, 3'b001, 32'h0E, 32'hABCD8001);
    run("sh0e", 3, 32'h0C, 32'h80010000, 0, 0, 0);
    issue(0, 3'b001, 32'h0E, 32'h0);
    run("lh0e", 2, 32'h0C, 0, 32'hFFFF8001, 0, 0);
    issue(0, 3'b101, 32'h0E, 32'h0);
    run("lhu0e", 2, 32'h0C, 0, 32'h00008001, 0, 0);

    issue(0, 3'b010, 32'h06, 32'h0);
    run("lw_mis", 0, 0, 0, 0, 1, 0);
    issue(0, 3'b001, 32'h05, 32'h0);
    run("lh_mis", 0, 0, 0, 0, 1, 0);
    issue(1, 3'b010, 32'h80, 32'h55555555);
    run("sw_oor", 0, 0, 0, 0, 0, 1);
    issue(0, 3'b010, 32'h81, 32'h0);
    run("lw_mis_oor", 0, 0, 0, 0, 1, 0);
    issue(0, 3'b011, 32'h00, 32'h0);
    run("ld_f3_011", 0, 0, 0, 0, 0, 1);
    issue(1, 3'b100, 32'h01, 32'h0);
    run("st_f3_100", 0, 0, 0, 0, 0, 1);

    // Request held during a busy SB is only taken in the response cycle.
    issue(1, 3'b000, 32'h00, 32'h0000005A);
    @(negedge clk);
    chk("hold_c1_read", mem_read, 1);
    chk("hold_c1_ready", req_ready, 0);
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    @(negedge clk);
    chk("hold_c2_ready", req_ready, 0);
    chk("hold_c2_read", mem_read, 0);
    @(negedge clk);
    chk("hold_c3_write", mem_write, 1);
    chk("hold_c3_wdata", mem_wdata, 32'h0000005A);
    chk("hold_c3_ready", req_ready, 0);
    @(negedge clk);
    chk("hold_c4_resp", resp_valid, 1);
    chk("hold_c4_ready", req_ready, 1);
    run("held_lw", 2, 32'h10, 0, 32'hA5223344, 0, 0);

    // Reset asserted in the CAP cycle of an SB.
    issue(1, 3'b000, 32'h01, 32'h00000077);
    @(negedge clk);
    chk("rstmid_rd", mem_read, 1);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_ready", req_ready, 1);
    chk("rstmid_ctl", {resp_valid, mem_read, mem_write}, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_wdata", mem_wdata, 0);
    @(negedge clk);
    chk("rstmid_hold", {resp_valid, mem_write}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstmid_after", {resp_valid, mem_write, mem_read}, 0);
    issue(0, 3'b010, 32'h00, 32'h0);
    run("lw00_after_rst", 2, 32'h00, 0, 32'h0, 0, 0);
    issue(0, 3'b010, 32'h10, 32'h0);
    run("lw10_after_rst", 2, 32'h10, 0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
